// File: rtl/dac_stream_ctrl_pkg.sv
// rtl/dac_stream_ctrl_pkg.sv - shared FSM encoding and default widths for the DAC stream controller
//
// Contents:
//   DAC_DW_DEFAULT   default DAC sample width
//   FIFO_AW_DEFAULT  default sample FIFO address width (depth = 2**FIFO_AW)
//   dac_state_t      controller FSM state encoding

package dac_stream_ctrl_pkg;

    localparam int DAC_DW_DEFAULT  = 10;
    localparam int FIFO_AW_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } dac_state_t;

endpackage

// File: rtl/dac_stream_ctrl_if.sv
// rtl/dac_stream_ctrl_if.sv - sample write port and DAC drive bundle
//
// Signals:
//   wr        sample write strobe (one sample per cycle)
//   wdata     sample to write
//   dac_data  code driven to the DAC
//   dac_load  one-cycle DAC latch strobe
//   dac_busy  conversion in progress (load or settle)
// Modports:
//   master  sample producer / DAC observer
//   slave   controller

interface dac_stream_ctrl_if
    import dac_stream_ctrl_pkg::*;
#(
    parameter int DW = DAC_DW_DEFAULT
);

    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] dac_data;
    logic          dac_load;
    logic          dac_busy;

    modport master (
        output wr,
        output wdata,
        input  dac_data,
        input  dac_load,
        input  dac_busy
    );

    modport slave (
        input  wr,
        input  wdata,
        output dac_data,
        output dac_load,
        output dac_busy
    );

endinterface

// File: rtl/dac_stream_ctrl_fifo.sv
// rtl/dac_stream_ctrl_fifo.sv - synchronous sample FIFO with first-word fall-through read
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (flushes pointers and level)
//   wr, w_data  write strobe and data; ignored when full, even if a read happens too
//   rd, r_data  read strobe; r_data always shows the head entry
//   empty, full status
//   level       occupancy 0..2**AW

module dac_fifo
    import dac_stream_ctrl_pkg::*;
#(
    parameter int DW = DAC_DW_DEFAULT,
    parameter int AW = FIFO_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_wr;
    logic          do_rd;

    // Level never exceeds DEPTH, so its MSB alone marks the exact full point.
    assign full   = level_q[AW];
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign r_data = mem[rd_ptr];

    // Full check uses the registered level: a pop in the same cycle does not
    // make room for the write.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= w_data;
        end
    end

endmodule

// File: rtl/dac_stream_ctrl.sv
// rtl/dac_stream_ctrl.sv - paced DAC sample streamer: prescaler, rate counter, FIFO and load/settle FSM
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              enable; low stops counters and returns the FSM to IDLE
//   clkdiv          prescaler match (tick every clkdiv+1 cycles)
//   rate            sample period in ticks minus one
//   settle          settle cycles after each load
//   fifo_threshold  refill threshold for fifo_below
//   clr_underrun    clears the sticky underrun flag (a simultaneous set wins)
//   underrun        sticky: a sample was due with the FIFO empty
//   fifo_full, fifo_empty, fifo_level, fifo_below  FIFO status
//   bus             sample write port and DAC outputs (slave side)

module dac_stream_ctrl
    import dac_stream_ctrl_pkg::*;
#(
    parameter int DW      = DAC_DW_DEFAULT,
    parameter int FIFO_AW = FIFO_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [7:0]         clkdiv,
    input  logic [7:0]         rate,
    input  logic [3:0]         settle,
    input  logic [FIFO_AW-1:0] fifo_threshold,
    input  logic               clr_underrun,
    output logic               underrun,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_below,
    dac_stream_ctrl_if.slave   bus
);

    dac_state_t    state_q;
    dac_state_t    state_d;

    logic [7:0]    presc_q;
    logic [7:0]    rate_q;
    logic          sample_req_q;
    logic          tick;
    logic          rate_hit;

    logic [3:0]    scnt_q;
    logic          settle_done;

    logic          pop;
    logic          underrun_set;
    logic          dac_load;
    logic          dac_busy;
    logic [DW-1:0] dac_data_q;
    logic          underrun_q;
    logic [DW-1:0] fifo_rdata;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    dac_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (bus.wr),
        .w_data (bus.wdata),
        .rd     (pop),
        .r_data (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    assign fifo_below = (fifo_level < {1'b0, fifo_threshold});

    // ------------------------------------------------------------------
    // Prescaler and rate counter
    // ------------------------------------------------------------------
    assign tick     = en && (presc_q == clkdiv);
    assign rate_hit = tick && (rate_q == rate);

    // sample_req is registered, so the first request lands exactly
    // (clkdiv+1)*(rate+1) cycles after en rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            rate_q       <= '0;
            sample_req_q <= 1'b0;
        end else if (!en) begin
            presc_q      <= '0;
            rate_q       <= '0;
            sample_req_q <= 1'b0;
        end else begin
            presc_q      <= tick ? 8'd0 : presc_q + 8'd1;
            if (tick) begin
                rate_q <= rate_hit ? 8'd0 : rate_q + 8'd1;
            end
            sample_req_q <= rate_hit;
        end
    end

    // ------------------------------------------------------------------
    // Settle counter: counts cycles spent in SETTLE, zero elsewhere
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
        end else if (en && (state_q == ST_SETTLE)) begin
            scnt_q <= scnt_q + 4'd1;
        end else begin
            scnt_q <= '0;
        end
    end

    // The comparison is >= so a settle value lowered mid-settle still exits.
    assign settle_done = ({1'b0, scnt_q} + 5'd1) >= {1'b0, settle};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WAIT;
                ST_WAIT:   if (sample_req_q && !fifo_empty) state_d = ST_LOAD;
                ST_LOAD:   state_d = (settle == 4'd0) ? ST_WAIT : ST_SETTLE;
                ST_SETTLE: if (settle_done) state_d = ST_WAIT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Requests seen outside WAIT are simply ignored, so overlapping
    // requests during LOAD/SETTLE are dropped without flagging underrun.
    // ------------------------------------------------------------------
    always_comb begin
        pop          = 1'b0;
        underrun_set = 1'b0;
        dac_load     = 1'b0;
        dac_busy     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (en && sample_req_q) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                dac_load = 1'b1;
                dac_busy = 1'b1;
            end
            ST_SETTLE: begin
                dac_busy = 1'b1;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // DAC code register and sticky underrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data_q <= '0;
        end else if (pop) begin
            dac_data_q <= fifo_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else if (underrun_set) begin
            underrun_q <= 1'b1;
        end else if (clr_underrun) begin
            underrun_q <= 1'b0;
        end
    end

    assign underrun     = underrun_q;
    assign bus.dac_data = dac_data_q;
    assign bus.dac_load = dac_load;
    assign bus.dac_busy = dac_busy;

endmodule
